// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the memory-access stage and its helpers.
//   - opcode / funct3 codes for loads and stores
//   - access-state encoding
//   - small decode helpers shared by the stage and the alignment unit
package lsu_stage_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_S);
  endfunction

  // size is funct3[1:0]: 0 byte, 1 half, otherwise word
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory port bundle (req/gnt/rvalid handshake).
//   master: the LSU (drives req/we/addr/wstrb/wdata, receives gnt/rvalid/rdata)
//   slave : the memory or D-cache
interface lsu_stage_if #(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [STRB_W-1:0] wstrb;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_stage_align.sv
// Combinational byte-lane logic for loads and stores.
//   funct3     : access size / signedness
//   addr_lo    : byte offset within the word
//   store_data : raw store operand -> wstrb / wdata (replicated per lane)
//   load_word  : raw memory word   -> load_data (extended)
//   misalign   : access crosses its natural alignment
module lsu_stage_align
  import lsu_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   load_word,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign
);

  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [7:0]      lb;
  logic [15:0]     lh;

  always_comb begin
    misalign   = addr_misaligned(funct3[1:0], addr_lo);
    byte_shift = load_word >> {addr_lo, 3'b000};
    half_shift = load_word >> {addr_lo[1], 4'b0000};
    lb         = byte_shift[7:0];
    lh         = half_shift[15:0];

    case (funct3)
      F3_LB:   load_data = {{(XLEN-8){lb[7]}}, lb};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, lb};
      F3_LH:   load_data = {{(XLEN-16){lh[15]}}, lh};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, lh};
      default: load_data = load_word;
    endcase

    // Data is replicated across lanes so the strobe alone selects the bytes.
    case (funct3[1:0])
      2'b00: begin
        wstrb = STRB_W'(1) << addr_lo;
        wdata = {STRB_W{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = STRB_W'(3) << {addr_lo[1], 1'b0};
        wdata = {(STRB_W/2){store_data[15:0]}};
      end
      default: begin
        wstrb = STRB_W'(4'hF);
        wdata = {(STRB_W/4){store_data[31:0]}};
      end
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access pipeline stage between execute and write-back.
//   clk, rst (async, active low)
//   E side : e_to_m_valid, m_allow_in, E_* payload, can_jump/jump_target
//   W side : w_allow_in, m_to_w_valid, m_valid, M_* payload, m_valM, m_misalign
//   dmem   : data-memory port (lsu_stage_if master)
//   stall_cnt : saturating count of cycles holding an instruction that is not ready
//
// state | meaning
// IDLE  | nothing in flight
// REQ   | dmem_req asserted, waiting for gnt
// WAIT  | granted, waiting for rvalid
// DONE  | result ready, waiting for W to take it
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_to_m_valid,
  output logic             m_allow_in,
  input  logic             w_allow_in,
  output logic             m_to_w_valid,
  output logic             m_valid,
  input  logic [6:0]       E_opcode,
  input  logic [9:0]       E_funct,
  input  logic [XLEN-1:0]  e_valE,
  input  logic [XLEN-1:0]  E_val2,
  input  logic [4:0]       E_rd,
  input  logic [XLEN-1:0]  E_default_pc,
  input  logic [XLEN-1:0]  E_cur_pc,
  input  logic [XLEN-1:0]  E_pred_pc,
  input  logic [31:0]      E_instr,
  input  logic             E_commit,
  input  logic             can_jump,
  input  logic [XLEN-1:0]  jump_target,
  output logic [6:0]       M_opcode,
  output logic [9:0]       M_funct,
  output logic [XLEN-1:0]  M_valE,
  output logic [XLEN-1:0]  M_val2,
  output logic [4:0]       M_rd,
  output logic [XLEN-1:0]  M_default_pc,
  output logic [XLEN-1:0]  M_cur_pc,
  output logic [31:0]      M_instr,
  output logic             M_commit,
  output logic [XLEN-1:0]  M_pred_pc,
  output logic [XLEN-1:0]  M_predicted_pc,
  output logic [XLEN-1:0]  m_valM,
  output logic             m_misalign,
  lsu_stage_if.master      dmem,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [9:0]      funct;
    logic [XLEN-1:0] vale;
    logic [XLEN-1:0] val2;
    logic [4:0]      rd;
    logic [XLEN-1:0] default_pc;
    logic [XLEN-1:0] cur_pc;
    logic [31:0]     instr;
    logic            commit;
    logic [XLEN-1:0] pred_pc;
    logic [XLEN-1:0] predicted_pc;
  } payload_t;

  lsu_state_e      state_q, state_d;
  payload_t        pl_q, pl_d;
  logic            m_valid_q, m_valid_d;
  logic [XLEN-1:0] m_valm_q, m_valm_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic            m_ready_go;
  logic            capture;
  logic            e_go_req;
  logic            m_is_load;
  logic [XLEN-1:0] load_data;
  logic            m_align_err;

  lsu_stage_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
    .funct3     (pl_q.funct[2:0]),
    .addr_lo    (pl_q.vale[1:0]),
    .store_data (pl_q.val2),
    .load_word  (dmem.rdata),
    .wstrb      (dmem.wstrb),
    .wdata      (dmem.wdata),
    .load_data  (load_data),
    .misalign   (m_align_err)
  );

  assign m_ready_go   = (state_q == ST_DONE);
  assign m_allow_in   = ~m_valid_q | (m_ready_go & w_allow_in);
  assign m_to_w_valid = m_valid_q & m_ready_go;
  assign capture      = m_allow_in & e_to_m_valid;
  // Only aligned loads/stores touch memory; everything else goes straight to DONE.
  assign e_go_req     = is_mem_op(E_opcode) & ~addr_misaligned(E_funct[1:0], e_valE[1:0]);
  assign m_is_load    = (pl_q.opcode == OP_LOAD);

  always_comb begin
    state_d     = state_q;
    pl_d        = pl_q;
    m_valid_d   = m_valid_q;
    m_valm_d    = m_valm_q;
    stall_cnt_d = stall_cnt_q;

    if (m_allow_in) m_valid_d = e_to_m_valid;

    if (capture) begin
      pl_d = '{opcode:       E_opcode,
               funct:        E_funct,
               vale:         e_valE,
               val2:         E_val2,
               rd:           E_rd,
               default_pc:   E_default_pc,
               cur_pc:       E_cur_pc,
               instr:        E_instr,
               commit:       E_commit,
               pred_pc:      can_jump ? jump_target : E_default_pc,
               predicted_pc: E_pred_pc};
      m_valm_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (capture) state_d = e_go_req ? ST_REQ : ST_DONE;
      end
      ST_REQ: begin
        if (dmem.gnt) begin
          if (dmem.rvalid) begin
            state_d = ST_DONE;
            if (m_is_load) m_valm_d = load_data;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem.rvalid) begin
          state_d = ST_DONE;
          if (m_is_load) m_valm_d = load_data;
        end
      end
      ST_DONE: begin
        if (w_allow_in) begin
          if (capture) state_d = e_go_req ? ST_REQ : ST_DONE;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (m_valid_q && !m_ready_go && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pl_q        <= '0;
      m_valid_q   <= 1'b0;
      m_valm_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pl_q        <= pl_d;
      m_valid_q   <= m_valid_d;
      m_valm_q    <= m_valm_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem.req  = (state_q == ST_REQ);
  assign dmem.we   = (pl_q.opcode == OP_S);
  assign dmem.addr = {pl_q.vale[XLEN-1:2], 2'b00};

  assign m_valid        = m_valid_q;
  assign m_valM         = m_valm_q;
  assign m_misalign     = m_valid_q & is_mem_op(pl_q.opcode) & m_align_err;
  assign stall_cnt      = stall_cnt_q;
  assign M_opcode       = pl_q.opcode;
  assign M_funct        = pl_q.funct;
  assign M_valE         = pl_q.vale;
  assign M_val2         = pl_q.val2;
  assign M_rd           = pl_q.rd;
  assign M_default_pc   = pl_q.default_pc;
  assign M_cur_pc       = pl_q.cur_pc;
  assign M_instr        = pl_q.instr;
  assign M_commit       = pl_q.commit;
  assign M_pred_pc      = pl_q.pred_pc;
  assign M_predicted_pc = pl_q.predicted_pc;

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: byte-addressed memory model, per-instruction expectations
// derived from load/store semantics, randomized ops, latencies and W back-pressure.
module tb_lsu_stage;
  import lsu_stage_pkg::*;

  localparam int XLEN = 32;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        e_to_m_valid, m_allow_in, w_allow_in, m_to_w_valid, m_valid;
  logic [6:0]  E_opcode, M_opcode;
  logic [9:0]  E_funct, M_funct;
  logic [31:0] e_valE, E_val2, E_default_pc, E_cur_pc, E_pred_pc, E_instr, jump_target;
  logic [4:0]  E_rd, M_rd;
  logic        E_commit, can_jump, M_commit, m_misalign;
  logic [31:0] M_valE, M_val2, M_default_pc, M_cur_pc, M_instr, M_pred_pc, M_predicted_pc;
  logic [31:0] m_valM, stall_cnt;

  lsu_stage_if #(.XLEN(XLEN)) dmem_if ();

  lsu_stage #(.XLEN(XLEN), .STRB_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in), .w_allow_in(w_allow_in),
    .m_to_w_valid(m_to_w_valid), .m_valid(m_valid),
    .E_opcode(E_opcode), .E_funct(E_funct), .e_valE(e_valE), .E_val2(E_val2), .E_rd(E_rd),
    .E_default_pc(E_default_pc), .E_cur_pc(E_cur_pc), .E_pred_pc(E_pred_pc),
    .E_instr(E_instr), .E_commit(E_commit), .can_jump(can_jump), .jump_target(jump_target),
    .M_opcode(M_opcode), .M_funct(M_funct), .M_valE(M_valE), .M_val2(M_val2), .M_rd(M_rd),
    .M_default_pc(M_default_pc), .M_cur_pc(M_cur_pc), .M_instr(M_instr), .M_commit(M_commit),
    .M_pred_pc(M_pred_pc), .M_predicted_pc(M_predicted_pc),
    .m_valM(m_valM), .m_misalign(m_misalign), .dmem(dmem_if), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  mem_b [0:1023];
  logic [31:0] exp_stall;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_b[{a[9:2], 2'b00} + 10'(i)];
    return w;
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[{a[9:2], 2'b00} + 10'(i)] = w[8*i +: 8];
  endtask

  // Little-endian read of nb bytes, then sign/zero extension.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(mem_b[10'(a + 32'(i))]) << (8 * i));
    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] v2, input int gl, input int rl, input int wl,
                       input logic cj, input logic [31:0] jt);
    logic mem_op, ld, go;
    int nb, lane;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [31:0] dpc, cpc, ppc, ins, exp_val, exp_w, exp_m;
    logic cm;
    logic [3:0] exp_s;
    logic [159:0] p1, p2;
    mem_op = (op == OP_LOAD) || (op == OP_S);
    ld     = (op == OP_LOAD);
    nb     = 1 << f3[1:0];
    lane   = int'(addr[1:0]);
    go     = mem_op && ((lane % nb) == 0);
    f7 = 7'($urandom); rd = 5'($urandom); dpc = $urandom; cpc = $urandom;
    ppc = $urandom; ins = $urandom; cm = 1'($urandom);
    p1 = 160'({op, f7, f3, addr, v2, rd});
    p2 = 160'({dpc, cpc, ins, cm, ppc});
    exp_val = '0; exp_s = '0; exp_w = '0; exp_m = '0;
    if (go && ld) exp_val = load_model(f3, addr);
    if (go && !ld)
      for (int i = 0; i < 4; i++)
        if (i >= lane && i < lane + nb) begin
          exp_s[i] = 1'b1;
          exp_m[8*i +: 8] = 8'hFF;
          exp_w[8*i +: 8] = v2[8*(i-lane) +: 8];
        end

    #1 chk("allow_in", m_allow_in, 1'b1);
    E_opcode = op; E_funct = {f7, f3}; e_valE = addr; E_val2 = v2; E_rd = rd;
    E_default_pc = dpc; E_cur_pc = cpc; E_pred_pc = ppc; E_instr = ins; E_commit = cm;
    can_jump = cj; jump_target = jt; e_to_m_valid = 1'b1;
    @(negedge clk);
    e_to_m_valid = 1'b0;
    chk("payload", {M_opcode, M_funct, M_valE, M_val2, M_rd}, p1);
    chk("pc_info", {M_default_pc, M_cur_pc, M_instr, M_commit, M_predicted_pc}, p2);
    chk("pred_pc", M_pred_pc, cj ? jt : dpc);

    if (go) begin
      for (int g = 0; g <= gl; g++) begin
        chk("req", dmem_if.req, 1'b1);
        chk("addr", dmem_if.addr, {addr[31:2], 2'b00});
        chk("we", dmem_if.we, !ld);
        chk("m2w_busy", m_to_w_valid, 1'b0);
        if (!ld) begin
          chk("wstrb", dmem_if.wstrb, exp_s);
          chk("wdata", dmem_if.wdata & exp_m, exp_w);
        end
        dmem_if.gnt    = (g == gl);
        dmem_if.rvalid = (g == gl) && (rl == 0);
        dmem_if.rdata  = (g == gl) ? word_at(addr) : $urandom;
        @(negedge clk);
        dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
      end
      for (int r = 1; r <= rl; r++) begin
        chk("req_wait", dmem_if.req, 1'b0);
        chk("m2w_wait", m_to_w_valid, 1'b0);
        dmem_if.rvalid = (r == rl);
        dmem_if.rdata  = (r == rl) ? word_at(addr) : $urandom;
        @(negedge clk);
        dmem_if.rvalid = 1'b0;
      end
      exp_stall = exp_stall + 32'(gl + 1 + rl);
      if (!ld) for (int i = 0; i < nb; i++) mem_b[10'(addr + 32'(i))] = v2[8*i +: 8];
    end

    chk("m2w_valid", m_to_w_valid, 1'b1);
    chk("valM", m_valM, exp_val);
    chk("misalign", m_misalign, mem_op && !go);
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("req_done", dmem_if.req, 1'b0);

    // W back-pressure: offered payload and stray rvalid must both be ignored.
    for (int i = 0; i < wl; i++) begin
      w_allow_in = 1'b0; e_to_m_valid = 1'b1; E_opcode = OP_LOAD; e_valE = $urandom;
      dmem_if.rvalid = 1'b1; dmem_if.rdata = $urandom;
      #1 chk("allow_in_hold", m_allow_in, 1'b0);
      @(negedge clk);
      chk("hold_m2w", m_to_w_valid, 1'b1);
      chk("hold_valM", m_valM, exp_val);
      chk("hold_payload", {M_opcode, M_funct, M_valE, M_val2, M_rd}, p1);
    end
    w_allow_in = 1'b1; e_to_m_valid = 1'b0; dmem_if.rvalid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    chk("drained", m_valid, 1'b0);
    chk("drained_m2w", m_to_w_valid, 1'b0);
  endtask

  initial begin
    logic [2:0] f3s [0:7];
    int k;
    f3s[0] = F3_LB; f3s[1] = F3_LH; f3s[2] = F3_LW; f3s[3] = F3_LBU; f3s[4] = F3_LHU;
    f3s[5] = F3_SB; f3s[6] = F3_SH; f3s[7] = F3_SW;
    e_to_m_valid = 0; w_allow_in = 1; E_opcode = 0; E_funct = 0; e_valE = 0; E_val2 = 0;
    E_rd = 0; E_default_pc = 0; E_cur_pc = 0; E_pred_pc = 0; E_instr = 0; E_commit = 0;
    can_jump = 0; jump_target = 0;
    dmem_if.gnt = 0; dmem_if.rvalid = 0; dmem_if.rdata = 0;
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);
    exp_stall = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_req", dmem_if.req, 1'b0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_valM", m_valM, 32'd0);
    chk("rst_misalign", m_misalign, 1'b0);
    chk("rst_payload", {M_opcode, M_valE, M_pred_pc, M_instr}, 160'd0);
    rst = 1'b1;
    @(negedge clk);

    put_word(32'h100, 32'hDEADBEEF);
    do_op(OP_LOAD, F3_LW, 32'h100, $urandom, 0, 0, 0, 1'b0, 0);
    drain();
    put_word(32'h100, 32'h80FFFFFF);
    do_op(OP_LOAD, F3_LB, 32'h103, $urandom, 0, 3, 0, 1'b0, 0);
    drain();
    do_op(OP_LOAD, F3_LBU, 32'h103, $urandom, 0, 0, 0, 1'b0, 0);
    drain();
    do_op(OP_S, F3_SH, 32'h202, 32'h1234, 1, 0, 0, 1'b0, 0);
    drain();
    do_op(OP_LOAD, F3_LW, 32'h101, $urandom, 0, 0, 0, 1'b0, 0);
    drain();
    do_op(OP_LOAD, F3_LW, 32'h104, $urandom, 0, 1, 3, 1'b0, 0);
    drain();
    // back-to-back handoffs, store then reload of the same word
    do_op(OP_ALU, 3'd0, $urandom, $urandom, 0, 0, 3, 1'b0, 0);
    do_op(OP_S, F3_SW, 32'h108, 32'hCAFEF00D, 0, 2, 0, 1'b0, 0);
    do_op(OP_LOAD, F3_LHU, 32'h10A, $urandom, 2, 0, 1, 1'b0, 0);
    drain();

    // reset lands while a load waits for rvalid
    #1 E_opcode = OP_LOAD; E_funct = {7'd0, F3_LW}; e_valE = 32'h108; e_to_m_valid = 1'b1;
    @(negedge clk);
    e_to_m_valid = 1'b0; dmem_if.gnt = 1'b1;
    @(negedge clk);
    dmem_if.gnt = 1'b0;
    chk("wait_valid", m_valid, 1'b1);
    chk("wait_stall", stall_cnt, exp_stall + 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 1'b0);
    chk("midrst_req", dmem_if.req, 1'b0);
    chk("midrst_stall", stall_cnt, 32'd0);
    chk("midrst_m2w", m_to_w_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_stall = 0;
    do_op(OP_ALU, 3'd0, $urandom, $urandom, 0, 0, 0, 1'b1, 32'h80);
    drain();

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      logic [6:0]  op;
      k  = $urandom_range(0, 8);
      op = (k < 5) ? OP_LOAD : (k < 8) ? OP_S : OP_ALU;
      f3 = (k < 8) ? f3s[k] : 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      do_op(op, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 2), 1'($urandom), $urandom);
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
Parametrised memory-access pipeline stage; the successor to the fixed single-cycle M stage. It sits between execute and write_back and captures the E->M payload under the valid/allow_in handshake. Loads and stores go to an external data memory (D-cache) port with req/gnt/rvalid handshake and arbitrary latency. The stage stalls (m_ready_go=0) until the access completes, then formats load data and flags misaligned accesses.

Parameters:
XLEN, 32, data/address width (32 only tested; 64 must elaborate)
STRB_W, XLEN/8, byte-strobe width
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
e_to_m_valid  in  1  E stage has valid payload
m_allow_in  out  1  stage can accept payload
w_allow_in  in  1  W stage can accept
m_to_w_valid  out  1  result valid to W
m_valid  out  1  stage holds an instruction
E_opcode  in  7  opcode
E_funct  in  10  {funct7,funct3}; funct3 = bits[2:0]
e_valE  in  XLEN  effective address / ALU result
E_val2  in  XLEN  store data
E_rd  in  5  destination
E_default_pc, E_cur_pc, E_pred_pc  in  XLEN  pc info
E_instr  in  32  instruction; E_commit in 1 commit flag
can_jump  in  1  branch taken; jump_target in XLEN
M_opcode/M_funct/M_valE/M_val2/M_rd/M_default_pc  out  as inputs  registered payload
M_cur_pc, M_instr, M_commit, M_pred_pc, M_predicted_pc  out  as inputs  difftest payload
m_valM  out  XLEN  formatted load data, held stable while m_to_w_valid=1
m_misalign  out  1  current instruction is misaligned load/store
dmem_req  out  1  request valid
dmem_we  out  1  1=store
dmem_addr  out  XLEN  word-aligned address
dmem_wstrb  out  STRB_W  byte enables
dmem_wdata  out  XLEN  lane-shifted store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  response (load data or store ack)
dmem_rdata  in  XLEN  load word
stall_cnt  out  CNT_W  cycles with m_valid=1 and m_ready_go=0

Behaviour:
- Reset (rst=0, async): m_valid=0, FSM=IDLE, dmem_req=0, stall_cnt=0, m_misalign=0, m_valM=0, all M_* payload=0.
- Capture: if m_allow_in && e_to_m_valid, latch payload. M_pred_pc <= can_jump ? jump_target : E_default_pc; M_predicted_pc <= E_pred_pc. m_valid <= e_to_m_valid whenever m_allow_in.
- m_allow_in = ~m_valid | (m_ready_go & w_allow_in); m_to_w_valid = m_valid & m_ready_go.
- FSM: IDLE, REQ, WAIT, DONE.
  - IDLE: at capture of a load/store (OP_LOAD/OP_S) that is aligned, go to REQ. Non-memory or misaligned ops go to DONE.
  - REQ: dmem_req=1, with addr/we/wstrb/wdata stable until dmem_gnt. On gnt go to WAIT. If gnt and rvalid arrive together, go straight to DONE.
  - WAIT: on dmem_rvalid, register formatted data into m_valM and go to DONE. rvalid in any other state is ignored.
  - DONE: m_ready_go=1. On handoff (w_allow_in), go to REQ if a new aligned memory op is captured in the same cycle, otherwise IDLE.
- m_ready_go=1 only in DONE. Zero-wait best case: a load is captured at cycle 0, has req at 1, has gnt+rvalid at 1, and is in DONE with m_to_w_valid at 2.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. On misalignment, m_misalign=1, no dmem request, m_valM=0, and the instruction proceeds to W.
- Load format, byte lane = addr[1:0]: LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW passes through.
- Store: SB strobe = 1<<addr[1:0], data replicated per byte. SH strobe = 0011/1100. SW strobe = 1111.
- dmem_addr = {addr[XLEN-1:2],2'b0}.
- stall_cnt saturates at all-ones.
- Reset mid-access drops the request. The bench must not issue rvalid after a reset.

Decomposition:
- Shared define.v supplies OP_LOAD, OP_S, funct3 codes (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2), and FSM state encodings.
- One sub-module, lsu_align: combinational strobe/wdata shift, load extension, and misalign detect. Reused by the future cached LSU.

Test Plan:
- LW at 0x100, gnt and rvalid both in cycle 1, rdata=0xDEADBEEF -> m_valM=0xDEADBEEF and m_to_w_valid at cycle 2; stall_cnt=1.
- LB at 0x103, rdata=0x80FFFFFF, 3-cycle rvalid delay -> m_valM=0xFFFFFF80, stall_cnt=4. LBU at the same address -> 0x00000080.
- SH at 0x202, val2=0x1234 -> dmem_addr=0x200, wstrb=1100, wdata[31:16]=0x1234, dmem_we=1; dmem_req held for 2 cycles until gnt.
- LW at 0x101 -> m_misalign=1, no dmem_req, m_to_w_valid the next cycle, m_valM=0.
- w_allow_in held low 3 cycles in DONE -> payload and m_valM stable, m_allow_in=0, e_to_m_valid not accepted.
- rst asserted while in WAIT -> immediately m_valid=0, dmem_req=0, stall_cnt=0. After release, a non-memory op passes in 1 cycle with correct M_pred_pc (can_jump=1, target=0x80 -> 0x80).
